// File: rtl/lanzador_cubos_if.sv
// ---------------------------------------------------------------------------
// lanzador_cubos_if
// Groups the signals that pass between the cube launcher and the rest of the
// game: the game-control inputs, the Cubo feedback, and the launch outputs.
//   master : the launcher side (lanzador_cubos)
//   slave  : the game / Cubo side that drives the controls and reads launches
// Signals:
//   habilitar_juego              game running (level)
//   juego_perdido                game over, sticky stop request
//   terminadoCubo                current cube has left the screen
//   start                        one-cycle launch pulse
//   posicion_x_inicial_aleatoria initial x of the launched cube (0..X_MAX)
//   velocidad_cubo_in            speed level 0..3
//   cubos_lanzados               launches issued, saturating at 255
//   detenido                     launcher permanently stopped
// ---------------------------------------------------------------------------
interface lanzador_cubos_if;
   logic       habilitar_juego;
   logic       juego_perdido;
   logic       terminadoCubo;
   logic       start;
   logic [8:0] posicion_x_inicial_aleatoria;
   logic [1:0] velocidad_cubo_in;
   logic [7:0] cubos_lanzados;
   logic       detenido;

   modport master (
      input  habilitar_juego,
      input  juego_perdido,
      input  terminadoCubo,
      output start,
      output posicion_x_inicial_aleatoria,
      output velocidad_cubo_in,
      output cubos_lanzados,
      output detenido
   );

   modport slave (
      output habilitar_juego,
      output juego_perdido,
      output terminadoCubo,
      input  start,
      input  posicion_x_inicial_aleatoria,
      input  velocidad_cubo_in,
      input  cubos_lanzados,
      input  detenido
   );
endinterface

// File: rtl/lanzador_cubos.sv
// ---------------------------------------------------------------------------
// lanzador_cubos
// Upstream stage of the falling-cube unit. Decides when each cube is
// launched, at which pseudo-random x and at which speed, and steps the speed
// up every CUBOS_POR_NIVEL completed cubes. Once the game is lost it parks in
// DETENIDO until reset.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    lanzador_cubos_if.master (controls in, launch outputs out)
// ---------------------------------------------------------------------------
module lanzador_cubos #(
   parameter int unsigned X_MAX           = 440,
   parameter int unsigned CUBOS_POR_NIVEL = 8,
   parameter int unsigned RETARDO_INICIO  = 4,
   parameter logic [8:0]  LFSR_SEMILLA    = 9'h1A5
) (
   input  logic             clk,
   input  logic             reset,
   lanzador_cubos_if.master bus
);

   localparam int CNT_W = (RETARDO_INICIO > 1) ? $clog2(RETARDO_INICIO) : 1;
   localparam int NIV_W = (CUBOS_POR_NIVEL > 1) ? $clog2(CUBOS_POR_NIVEL) : 1;

   localparam logic [CNT_W-1:0] CNT_INI_C  = CNT_W'(RETARDO_INICIO - 1);
   localparam logic [NIV_W-1:0] NIV_ULT_C  = NIV_W'(CUBOS_POR_NIVEL - 1);
   localparam logic [8:0]       X_MAX_C    = 9'(X_MAX);
   localparam logic [8:0]       X_OFF_C    = 9'(X_MAX + 1);
   // An all-zero seed would lock the LFSR, so it is replaced by 1.
   localparam logic [8:0]       SEMILLA_C  = (LFSR_SEMILLA == 9'h000) ? 9'h001 : LFSR_SEMILLA;

   typedef enum logic [2:0] {
      INACTIVO = 3'd0,
      ESPERA   = 3'd1,
      LANZAR   = 3'd2,
      CAYENDO  = 3'd3,
      DETENIDO = 3'd4
   } estado_t;

   estado_t          estado_r;
   logic [CNT_W-1:0] cnt_r;
   logic [NIV_W-1:0] nivel_r;
   logic [8:0]       lfsr_r;
   logic             start_r;
   logic [8:0]       x_r;
   logic [1:0]       velocidad_r;
   logic [7:0]       cubos_r;
   logic             detenido_r;

   // Fibonacci step for x^9 + x^5 + 1 (taps on bits 9 and 5).
   function automatic logic [8:0] lfsr_siguiente(input logic [8:0] v);
      return {v[7:0], v[8] ^ v[4]};
   endfunction

   // Folds 0..511 into 0..X_MAX; with X_MAX >= 255 one subtraction suffices.
   function automatic logic [8:0] mapear_x(input logic [8:0] v);
      return (v <= X_MAX_C) ? v : (v - X_OFF_C);
   endfunction

   // LFSR: free-running in every state, only reset reloads the seed
   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_r <= SEMILLA_C;
      end else begin
         lfsr_r <= lfsr_siguiente(lfsr_r);
      end
   end

   // Launch sequencer with registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         estado_r    <= INACTIVO;
         cnt_r       <= {CNT_W{1'b0}};
         nivel_r     <= {NIV_W{1'b0}};
         start_r     <= 1'b0;
         x_r         <= 9'd0;
         velocidad_r <= 2'd0;
         cubos_r     <= 8'd0;
         detenido_r  <= 1'b0;
      end else begin
         // start is a single-cycle pulse; only the ESPERA->LANZAR edge raises it
         start_r <= 1'b0;
         case (estado_r)
            INACTIVO: begin
               if (bus.juego_perdido) begin
                  estado_r   <= DETENIDO;
                  detenido_r <= 1'b1;
               end else if (bus.habilitar_juego) begin
                  estado_r <= ESPERA;
                  cnt_r    <= CNT_INI_C;
               end else begin
                  estado_r <= INACTIVO;
               end
            end
            ESPERA: begin
               if (bus.juego_perdido) begin
                  estado_r   <= DETENIDO;
                  detenido_r <= 1'b1;
               end else if (!bus.habilitar_juego) begin
                  estado_r <= INACTIVO;
               end else if (cnt_r == {CNT_W{1'b0}}) begin
                  // x and the launch count settle on the same edge as start
                  estado_r <= LANZAR;
                  start_r  <= 1'b1;
                  x_r      <= mapear_x(lfsr_r);
                  if (cubos_r != 8'd255) begin
                     cubos_r <= cubos_r + 8'd1;
                  end else begin
                     cubos_r <= cubos_r;
                  end
               end else begin
                  cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            LANZAR: begin
               if (bus.juego_perdido) begin
                  estado_r   <= DETENIDO;
                  detenido_r <= 1'b1;
               end else begin
                  estado_r <= CAYENDO;
               end
            end
            CAYENDO: begin
               // A lost game wins over a simultaneous cube completion.
               if (bus.juego_perdido) begin
                  estado_r   <= DETENIDO;
                  detenido_r <= 1'b1;
               end else if (bus.terminadoCubo) begin
                  estado_r <= ESPERA;
                  cnt_r    <= CNT_INI_C;
                  if (nivel_r == NIV_ULT_C) begin
                     nivel_r <= {NIV_W{1'b0}};
                     if (velocidad_r != 2'd3) begin
                        velocidad_r <= velocidad_r + 2'd1;
                     end else begin
                        velocidad_r <= velocidad_r;
                     end
                  end else begin
                     nivel_r <= nivel_r + {{(NIV_W-1){1'b0}}, 1'b1};
                  end
               end else begin
                  estado_r <= CAYENDO;
               end
            end
            DETENIDO: begin
               estado_r   <= DETENIDO;
               detenido_r <= 1'b1;
            end
            default: begin
               // An illegal encoding is treated as a stop: nothing is launched.
               estado_r   <= DETENIDO;
               detenido_r <= 1'b1;
            end
         endcase
      end
   end

   assign bus.start                        = start_r;
   assign bus.posicion_x_inicial_aleatoria = x_r;
   assign bus.velocidad_cubo_in            = velocidad_r;
   assign bus.cubos_lanzados               = cubos_r;
   assign bus.detenido                     = detenido_r;

endmodule

// File: tb/tb_lanzador_cubos.sv
// ---------------------------------------------------------------------------
// tb_lanzador_cubos
// Self-checking bench for lanzador_cubos. The reference is event level: the
// launch must appear exactly RETARDO cycles after the triggering edge, x comes
// from a precomputed LFSR sequence indexed by cycles since reset, speed is
// min(3, completions / CUBOS_POR_NIVEL) and the launch count saturates at 255.
// ---------------------------------------------------------------------------
module tb_lanzador_cubos;

   localparam int          X_MAX   = 440;
   localparam int          NIVEL   = 8;
   localparam int          RETARDO = 4;
   localparam logic [8:0]  SEMILLA = 9'h1A5;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   lanzador_cubos_if bus_i ();

   lanzador_cubos #(
      .X_MAX           (X_MAX),
      .CUBOS_POR_NIVEL (NIVEL),
      .RETARDO_INICIO  (RETARDO),
      .LFSR_SEMILLA    (SEMILLA)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_i.master)
   );

   always #5 clk = ~clk;

   int flancos = 0;
   always @(posedge clk) flancos <= flancos + 1;

   int checks = 0;
   int failures = 0;
   int r_edge = 0;
   int lanzados_m = 0;
   int completados_m = 0;
   int prev_x = -1;
   int rep_x = 0;
   logic [8:0] seq [0:510];

   task automatic comprobar(input string tag, input int obs, input int esp);
      checks++;
      if (obs != esp) begin
         failures++;
         $display("FAIL %s: obtenido=%0d esperado=%0d (t=%0t)", tag, obs, esp, $time);
      end
   endtask

   // Expected x for a launch whose lfsr sample is k cycles after reset.
   function automatic int x_ref(input int k);
      int v;
      v = int'(seq[k % 511]);
      return (v <= X_MAX) ? v : v - (X_MAX + 1);
   endfunction

   function automatic int vel_ref();
      return (completados_m / NIVEL > 3) ? 3 : completados_m / NIVEL;
   endfunction

   task automatic aplicar_reset(input int n);
      reset = 1'b1;
      bus_i.habilitar_juego = 1'b0;
      bus_i.juego_perdido   = 1'b0;
      bus_i.terminadoCubo   = 1'b0;
      repeat (n) @(negedge clk);
      r_edge = flancos;
      reset = 1'b0;
      lanzados_m    = 0;
      completados_m = 0;
      prev_x = -1;
      rep_x  = 0;
   endtask

   // Waits (bounded) for the start pulse triggered at edge e_trig.
   task automatic esperar_lanzamiento(input int e_trig);
      bit visto;
      int xo;
      visto = 1'b0;
      for (int i = 0; i < RETARDO + 12 && !visto; i++) begin
         // terminadoCubo noise outside CAYENDO must be ignored
         if (i != 0) bus_i.terminadoCubo = ($urandom_range(0, 3) == 0);
         @(negedge clk);
         if (bus_i.start === 1'b1) visto = 1'b1;
      end
      bus_i.terminadoCubo = 1'b0;
      comprobar("start_visto", int'(visto), 1);
      if (visto) begin
         comprobar("t_start", flancos, e_trig + RETARDO);
         xo = int'(bus_i.posicion_x_inicial_aleatoria);
         comprobar("x_modelo", xo, x_ref(flancos - 1 - r_edge));
         comprobar("x_rango", int'(xo <= X_MAX), 1);
         if (xo == prev_x) rep_x++;
         else rep_x = 1;
         prev_x = xo;
         comprobar("x_repite", int'(rep_x >= 4), 0);
         comprobar("vel_lanz", int'(bus_i.velocidad_cubo_in), vel_ref());
         if (lanzados_m < 255) lanzados_m++;
      end
   endtask

   task automatic tras_lanzamiento();
      @(negedge clk);
      comprobar("start_1ciclo", int'(bus_i.start), 0);
      comprobar("cubos", int'(bus_i.cubos_lanzados), lanzados_m);
      comprobar("detenido_0", int'(bus_i.detenido), 0);
   endtask

   // Completes the falling cube after a random delay and checks the relaunch.
   task automatic completar();
      int d;
      int e;
      d = $urandom_range(0, 4);
      for (int i = 0; i < d; i++) begin
         // dropping the enable must not abort a falling cube
         bus_i.habilitar_juego = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      bus_i.habilitar_juego = 1'b1;
      bus_i.terminadoCubo   = 1'b1;
      e = flancos + 1;
      completados_m++;
      esperar_lanzamiento(e);
      tras_lanzamiento();
   endtask

   initial begin
      int e;
      int n_start;
      int x_guard;
      int v_guard;

      seq[0] = SEMILLA;
      for (int i = 1; i < 511; i++) seq[i] = {seq[i-1][7:0], seq[i-1][8] ^ seq[i-1][4]};

      // reset state
      aplicar_reset(3);
      comprobar("rst_start", int'(bus_i.start), 0);
      comprobar("rst_x", int'(bus_i.posicion_x_inicial_aleatoria), 0);
      comprobar("rst_vel", int'(bus_i.velocidad_cubo_in), 0);
      comprobar("rst_cubos", int'(bus_i.cubos_lanzados), 0);
      comprobar("rst_detenido", int'(bus_i.detenido), 0);

      // launch timing from enable
      repeat (5) @(negedge clk);
      bus_i.habilitar_juego = 1'b1;
      e = flancos + 1;
      esperar_lanzamiento(e);
      tras_lanzamiento();
      comprobar("cubos_1", int'(bus_i.cubos_lanzados), 1);

      // level-up to saturation
      for (int i = 0; i < 40; i++) completar();
      comprobar("vel_sat", int'(bus_i.velocidad_cubo_in), 3);
      comprobar("cubos_41", int'(bus_i.cubos_lanzados), 41);

      // game lost together with a completion
      x_guard = int'(bus_i.posicion_x_inicial_aleatoria);
      v_guard = int'(bus_i.velocidad_cubo_in);
      bus_i.juego_perdido = 1'b1;
      bus_i.terminadoCubo = 1'b1;
      @(negedge clk);
      bus_i.juego_perdido = 1'b0;
      bus_i.terminadoCubo = 1'b0;
      comprobar("perdido_detenido", int'(bus_i.detenido), 1);
      comprobar("perdido_vel", int'(bus_i.velocidad_cubo_in), v_guard);
      n_start = 0;
      bus_i.habilitar_juego = 1'b1;
      for (int i = 0; i < 100; i++) begin
         bus_i.terminadoCubo = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (bus_i.start !== 1'b0) n_start++;
      end
      bus_i.terminadoCubo = 1'b0;
      comprobar("detenido_sin_start", n_start, 0);
      comprobar("detenido_sigue", int'(bus_i.detenido), 1);
      comprobar("detenido_x", int'(bus_i.posicion_x_inicial_aleatoria), x_guard);
      comprobar("detenido_vel", int'(bus_i.velocidad_cubo_in), v_guard);
      comprobar("detenido_cubos", int'(bus_i.cubos_lanzados), lanzados_m);

      // enable drop during ESPERA, then a full delay on re-raise
      aplicar_reset(2);
      comprobar("reset_sale_detenido", int'(bus_i.detenido), 0);
      bus_i.habilitar_juego = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus_i.habilitar_juego = 1'b0;
      n_start = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus_i.start !== 1'b0) n_start++;
      end
      comprobar("caida_sin_start", n_start, 0);
      bus_i.habilitar_juego = 1'b1;
      e = flancos + 1;
      esperar_lanzamiento(e);
      tras_lanzamiento();

      // reset during LANZAR after a level-up
      for (int i = 0; i < NIVEL; i++) completar();
      bus_i.terminadoCubo = 1'b1;
      e = flancos + 1;
      completados_m++;
      esperar_lanzamiento(e);
      aplicar_reset(1);
      comprobar("rl_start", int'(bus_i.start), 0);
      comprobar("rl_cubos", int'(bus_i.cubos_lanzados), 0);
      comprobar("rl_vel", int'(bus_i.velocidad_cubo_in), 0);
      comprobar("rl_x", int'(bus_i.posicion_x_inicial_aleatoria), 0);
      comprobar("rl_detenido", int'(bus_i.detenido), 0);
      // the next x confirms the LFSR went back to its seed
      bus_i.habilitar_juego = 1'b1;
      e = flancos + 1;
      esperar_lanzamiento(e);
      tras_lanzamiento();

      // range and launch-count saturation
      for (int i = 0; i < 300; i++) completar();
      comprobar("cubos_sat", int'(bus_i.cubos_lanzados), 255);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
